apb_master: RTL and testbench
=============================

# apb_master

APB requester that converts a single-outstanding command/response handshake into APB SETUP/ACCESS transfers toward an `apb_slave`. It is the initiator end of the APB interface `apb_intf`: it drives `paddr`, `pwdata`, `pselx`, `pwrite` and `penable`, and it samples `prdata`, `pready` and `pslave_error`. It adds an optional `pready` timeout so a hung slave cannot stall the system, and it holds each response until the upstream logic consumes it.

## Interface
- `ADDR_W`, default 32: width of `paddr` and `cmd_addr`.
- `DATA_W`, default 32: width of `pwdata`, `prdata`, `cmd_wdata` and `rsp_rdata`.
- `TIMEOUT`, default 16: maximum ACCESS cycles to wait for `pready`. A value of 0 disables the timeout.

Ports (name, direction, width, meaning):
- `pclk` input 1: the only clock. All logic is rising-edge.
- `preset` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: a command is offered.
- `cmd_ready` output 1: the block accepts a command this cycle.
- `cmd_write` input 1: 1 for write, 0 for read.
- `cmd_addr` input ADDR_W: transfer address.
- `cmd_wdata` input DATA_W: write data.
- `rsp_valid` output 1: a response is held.
- `rsp_ready` input 1: upstream consumes the response.
- `rsp_rdata` output DATA_W: read data. It is 0 for writes and for timeouts.
- `rsp_error` output 1: the slave signalled an error, or a timeout occurred.
- `rsp_timeout` output 1: the transfer was terminated by the timeout.
- `paddr` output ADDR_W, `pwdata` output DATA_W, `pwrite` output 1, `pselx` output 1, `penable` output 1: APB requester outputs.
- `prdata` input DATA_W, `pready` input 1, `pslave_error` input 1: APB completer inputs.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` is high, the block captures write, addr and wdata into registers and moves to SETUP.
  - For reads, the captured wdata is forced to 0.
- SETUP:
  - `pselx`=1, `penable`=0.
  - `paddr`, `pwrite` and `pwdata` drive the captured values.
  - The FSM always moves to ACCESS after one cycle.
- ACCESS:
  - `pselx`=1, `penable`=1; the address, control and data outputs stay unchanged.
  - If `pready`=1 in a cycle: capture `prdata` (reads only, else 0) into `rsp_rdata`, capture `pslave_error` into `rsp_error`, set `rsp_timeout`=0, and move to RESP.
  - If `pready` is still 0 after TIMEOUT ACCESS cycles (TIMEOUT≠0): move to RESP with `rsp_error`=1, `rsp_timeout`=1 and `rsp_rdata`=0.
  - The timeout counter is ceil(log2(TIMEOUT+1)) bits wide. It clears on entry to SETUP, increments each ACCESS cycle without `pready`, and saturates rather than wrapping.
  - `pready` and timeout in the same cycle: `pready` wins, and the response is normal.
- RESP:
  - `pselx`=0, `penable`=0, `rsp_valid`=1, `cmd_ready`=0.
  - When `rsp_ready` is high, the FSM moves to IDLE. A new command can be accepted in the following cycle.
- Outside SETUP and ACCESS, `paddr`, `pwrite` and `pwdata` hold their last values. They are 0 after reset.
- Only one transfer is outstanding at a time. Commands offered while `cmd_ready`=0 are ignored; the upstream logic holds `cmd_valid`.

## Timing
- Reset: while `preset` is asserted, every output goes to 0 immediately (asynchronously), except `cmd_ready`, which is 1. The FSM goes to IDLE.
- Reset asserted mid-transfer aborts the transfer with no response. `pselx` and `penable` drop in the same cycle as the reset.
- Minimum latency for a zero-wait-state slave:
  - Cycle 0: command accepted.
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS with `pready` high.
  - Cycle 3: `rsp_valid`=1.
- Each slave wait state adds one cycle.
- Minimum command-to-command spacing is 4 cycles, with `rsp_ready` tied high.
- `penable` rises exactly one cycle after `pselx`. Both fall together in the cycle after the `pready` sample.
- Response fields are stable while `rsp_valid`=1.

## Structure
- `apb_pkg` holds:
  - the `apb_state_e` enum (IDLE, SETUP, ACCESS, RESP);
  - default `ADDR_W` and `DATA_W` localparams;
  - a `apb_cmd_t` struct (write, addr, wdata);
  - a `apb_rsp_t` struct (rdata, error, timeout).
- `apb_master` is a single module; no sub-module is needed. The timeout counter stays inline.

## Test plan
- Write, no wait states: cmd write addr 0x0000_0010, data 0xDEAD_BEEF, `pready` tied 1.
  - Required: SETUP at cycle 1, ACCESS at cycle 2.
  - Required: `pwdata`=0xDEAD_BEEF throughout SETUP and ACCESS.
  - Required: `rsp_valid` at cycle 3 with `rsp_error`=0.
- Read with 3 wait states: cmd read addr 0x0000_0020, slave returns 0x1234_5678 on the 4th ACCESS cycle.
  - Required: `rsp_rdata`=0x1234_5678.
  - Required: `penable` high for exactly 4 cycles.
  - Required: `paddr` stable throughout.
- Slave error: read with `pslave_error`=1 at `pready`.
  - Required: `rsp_error`=1, `rsp_timeout`=0.
- Timeout: TIMEOUT=16, `pready` held 0.
  - Required: exactly 16 ACCESS cycles, then `rsp_valid` with `rsp_error`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - Required: `pselx` and `penable` low afterward.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles. Required: the response stays stable, `cmd_ready`=0, and a second `cmd_valid` is ignored until the handshake.
  - Then assert `preset` during ACCESS. Required: `pselx`, `penable` and `rsp_valid` are 0 at once, `cmd_ready`=1 after release, and no response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the APB requester: FSM state encoding and
// command/response record layouts at the default bus widths.
package apb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  error;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: one outstanding command becomes a SETUP/ACCESS transfer whose
// result is held as a response until consumed; optional pready timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              pselx,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslave_error
);

  // A disabled timeout still gets a 1-bit counter so the width is never zero.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

  apb_state_e        state_q;
  logic [TW-1:0]     cnt_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_error_q;
  logic              rsp_timeout_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              pselx_q;
  logic              penable_q;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pwrite_q      <= 1'b0;
      pselx_q       <= 1'b0;
      penable_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q     <= cmd_addr;
            pwrite_q    <= cmd_write;
            pwdata_q    <= cmd_write ? cmd_wdata : '0;
            pselx_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready is tested first so a same-cycle timeout yields a normal response.
          if (pready) begin
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            rsp_error_q   <= pslave_error;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= RESP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pwrite      = pwrite_q;
  assign pselx       = pselx_q;
  assign penable     = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table of single transfers against a
// scripted slave, then backpressure and mid-transfer reset sequences.
module tb_apb_master;
  import apb_pkg::*;

  logic        pclk;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        pselx;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslave_error;

  int n_checks;
  int n_fail;

  apb_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pwrite      (pwrite),
    .pselx       (pselx),
    .penable     (penable),
    .prdata      (prdata),
    .pready      (pready),
    .pslave_error(pslave_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // waits < 0 means the slave never raises pready.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prd;
    int          waits;
    logic        serr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          acc;
    int          lat;
    int          exp_acc;
    logic [31:0] exp_wd;
    logic        addr_ok;
    logic        data_ok;
    exp_wd  = v.wr ? v.wdata : 32'h0;
    exp_acc = (v.waits < 0) ? 16 : v.waits + 1;
    check("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    prdata    = v.prd;
    tick();
    lat       = 1;
    cmd_valid = 1'b0;
    check("setup_pselx", 64'(pselx), 64'(1));
    check("setup_penable", 64'(penable), 64'(0));
    check("setup_paddr", 64'(paddr), 64'(v.addr));
    check("setup_pwdata", 64'(pwdata), 64'(exp_wd));
    check("setup_pwrite", 64'(pwrite), 64'(v.wr));
    tick();
    lat++;
    acc     = 0;
    addr_ok = 1'b1;
    data_ok = 1'b1;
    while (pselx && penable && acc < 40) begin
      acc++;
      if (paddr !== v.addr) addr_ok = 1'b0;
      if (pwdata !== exp_wd) data_ok = 1'b0;
      pready       = (v.waits >= 0) && (acc == v.waits + 1);
      pslave_error = pready & v.serr;
      tick();
      lat++;
    end
    pready       = 1'b0;
    pslave_error = 1'b0;
    check("access_paddr_stable", 64'(addr_ok), 64'(1));
    check("access_pwdata_stable", 64'(data_ok), 64'(1));
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("rsp_latency", 64'(lat), 64'(2 + exp_acc));
    check("rsp_valid", 64'(rsp_valid), 64'(1));
    check("rsp_pselx_low", 64'(pselx), 64'(0));
    check("rsp_penable_low", 64'(penable), 64'(0));
    check("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    check("rsp_error", 64'(rsp_error), 64'(v.exp_err));
    check("rsp_timeout", 64'(rsp_timeout), 64'(v.exp_to));
    check("rsp_cmd_ready", 64'(cmd_ready), 64'(0));
    check("rsp_paddr_hold", 64'(paddr), 64'(v.addr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'(0));
    check("post_cmd_ready", 64'(cmd_ready), 64'(1));
    $display("vec %0d: wr=%0d addr=0x%08h waits=%0d -> acc=%0d lat=%0d rdata=0x%08h err=%0d to=%0d",
             idx, v.wr, v.addr, v.waits, acc, lat, rsp_rdata, rsp_error, rsp_timeout);
  endtask

  initial begin
    logic [31:0] held_rdata;
    logic        stable;
    logic        ignored;
    n_checks     = 0;
    n_fail       = 0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = 32'h0;
    cmd_wdata    = 32'h0;
    rsp_ready    = 1'b0;
    prdata       = 32'h0;
    pready       = 1'b0;
    pslave_error = 1'b0;
    preset       = 1'b1;

    //            wr    addr          wdata         prdata        waits serr exp_rdata     err   to
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hAAAA_5555, 0,  1'b0, 32'h0,         1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h5A5A_5A5A, 32'h1234_5678, 3,  1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,         32'hCAFE_F00D, 0,  1'b1, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0040, 32'h1111_1111, 32'hFFFF_FFFF, -1, 1'b0, 32'h0,         1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h7777_7777, 15, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 2,  1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'h1357_9BDF, 32'h2468_ACE0, 1,  1'b1, 32'h0,         1'b1, 1'b0};

    #2;
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_pselx", 64'(pselx), 64'(0));
    check("reset_penable", 64'(penable), 64'(0));
    check("reset_paddr", 64'(paddr), 64'(0));
    check("reset_pwdata", 64'(pwdata), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    $display("reset: cmd_ready=%0d rsp_valid=%0d pselx=%0d", cmd_ready, rsp_valid, pselx);
    tick();
    tick();
    preset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Backpressure: response held for 5 cycles while a second command waits.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0050;
    cmd_wdata = 32'h0;
    prdata    = 32'h9ABC_DEF0;
    tick();
    cmd_addr  = 32'h0000_0060;
    tick();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
    held_rdata = rsp_rdata;
    check("bp_rdata", 64'(held_rdata), 64'(32'h9ABC_DEF0));
    stable  = 1'b1;
    ignored = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!rsp_valid || rsp_rdata !== held_rdata || rsp_error !== 1'b0) stable = 1'b0;
      if (cmd_ready !== 1'b0 || pselx !== 1'b0) ignored = 1'b0;
    end
    check("bp_rsp_stable", 64'(stable), 64'(1));
    check("bp_cmd_ignored", 64'(ignored), 64'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_handshake_valid", 64'(rsp_valid), 64'(0));
    check("bp_handshake_pselx", 64'(pselx), 64'(0));
    check("bp_handshake_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    check("bp_second_setup", 64'(pselx), 64'(1));
    check("bp_second_addr", 64'(paddr), 64'(32'h0000_0060));
    $display("backpressure: held 0x%08h for 5 cycles, second cmd addr=0x%08h", held_rdata, paddr);

    // Reset during ACCESS aborts the transfer with no response.
    tick();
    check("rst_in_access", 64'(penable), 64'(1));
    preset = 1'b1;
    #1;
    check("rst_pselx", 64'(pselx), 64'(0));
    check("rst_penable", 64'(penable), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    tick();
    preset = 1'b0;
    pready = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid !== 1'b0 || pselx !== 1'b0 || cmd_ready !== 1'b1) stable = 1'b0;
    end
    pready = 1'b0;
    check("rst_no_response", 64'(stable), 64'(1));
    $display("reset abort: rsp_valid=%0d cmd_ready=%0d pselx=%0d", rsp_valid, cmd_ready, pselx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
